// File: rtl/h14tx_island_scheduler_if.sv
// ---------------------------------------------------------------------------
// h14tx_island_scheduler_if
//
// Packet-source side of the HDMI data-island scheduler. The packet builders
// (AVI, audio, ACR, ...) raise a level request and the scheduler answers with a
// one-hot grant that is held for the full 32-cycle packet slot.
//
// Signals
//   req        packet sources -> scheduler, one level request bit per source
//   grant      scheduler -> sources, one-hot, held for all 32 packet cycles
//   pkt_start  scheduler -> sources, pulse on the first cycle of a packet
//   pkt_idx    scheduler -> sources, cycle index 0..31 inside the packet
//
// Modports
//   master     packet-source view (drives req)
//   slave      scheduler view (drives grant/pkt_start/pkt_idx)
// ---------------------------------------------------------------------------
interface h14tx_island_scheduler_if #(
    parameter int NumReq = 3
) ();

    logic [NumReq-1:0] req;
    logic [NumReq-1:0] grant;
    logic              pkt_start;
    logic [4:0]        pkt_idx;

    modport master (
        output req,
        input  grant,
        input  pkt_start,
        input  pkt_idx
    );

    modport slave (
        input  req,
        output grant,
        output pkt_start,
        output pkt_idx
    );

endinterface

// File: rtl/h14tx_island_scheduler.sv
// ---------------------------------------------------------------------------
// h14tx_island_scheduler
//
// Places HDMI data islands into the Control gaps of the h14tx_timings stream.
// Packet sources are served round-robin, one 32-cycle packet slot per grant,
// and the outgoing period is overridden with the island preamble, guard bands
// and packet (DataActive) periods. Sits between h14tx_timings and the TMDS
// channel encoders.
//
// Ports
//   clk        pixel clock
//   rst        synchronous, active-high reset
//   x          horizontal cursor from h14tx_timings
//   period_in  period from h14tx_timings
//   period     period_in, or DataPreamble/DataGuard/DataActive inside an island
//   overrun    pulse: period_in left Control while an island was in flight
//   pktBus     slave side of h14tx_island_scheduler_if (req/grant/pkt_start/pkt_idx)
//
// Period encoding (shared with h14tx_timings):
//   0 Control, 1 VideoPreamble, 2 VideoGuard, 3 VideoActive,
//   4 DataPreamble, 5 DataGuard, 6 DataActive
//
// Build option
//   H14TX_ISLAND_ONE_PER_LINE_EN  when defined, at most one island per line.
//   Default (undefined): a new island may start as soon as HOLD finishes.
// ---------------------------------------------------------------------------
module h14tx_island_scheduler #(
    parameter int NumReq      = 3,
    parameter int MaxPackets  = 2,
    parameter int HoldOff     = 4,
    parameter int BitWidth    = 11,
    parameter int FrameWidth  = 1650,
    parameter int ActiveWidth = 1280
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BitWidth-1:0]     x,
    input  logic [2:0]              period_in,
    output logic [2:0]              period,
    output logic                    overrun,
    h14tx_island_scheduler_if.slave pktBus
);

    // Elaboration-time sanity checks on the configuration.
    if (NumReq < 1 || NumReq > 8) begin : gBadNumReq
        $error("h14tx_island_scheduler: NumReq must be 1..8");
    end
    if (MaxPackets < 1 || MaxPackets > 18) begin : gBadMaxPackets
        $error("h14tx_island_scheduler: MaxPackets must be 1..18");
    end
    if (ActiveWidth + 45 + HoldOff > FrameWidth - 10) begin : gNoRoom
        $error("h14tx_island_scheduler: horizontal blanking too short for one island");
    end

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (HoldOff > 32) ? $clog2(HoldOff) : 5;

    localparam logic [2:0] PerControl      = 3'd0;
    localparam logic [2:0] PerDataPreamble = 3'd4;
    localparam logic [2:0] PerDataGuard    = 3'd5;
    localparam logic [2:0] PerDataActive   = 3'd6;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPre    = 3'd1;
    localparam logic [2:0] StLguard = 3'd2;
    localparam logic [2:0] StPkt    = 3'd3;
    localparam logic [2:0] StTguard = 3'd4;
    localparam logic [2:0] StHold   = 3'd5;

    // Room math is one bit wider than x so x + need never wraps.
    // StartNeed: decision cycle + 8 pre + 2 guard + 32 pkt + 2 guard + hold
    // must all end before the video preamble start (Vps).
    localparam logic [BitWidth:0] Vps       = (BitWidth+1)'(FrameWidth - 10);
    localparam logic [BitWidth:0] StartNeed = (BitWidth+1)'(45 + HoldOff);
    localparam logic [BitWidth:0] NextNeed  = (BitWidth+1)'(35 + HoldOff);
    localparam logic [CntW-1:0]   HoldLast  = CntW'((HoldOff > 0) ? HoldOff - 1 : 0);

    logic [2:0]        state;
    logic [2:0]        stateNext;
    logic [CntW-1:0]   cnt;
    logic [CntW-1:0]   cntNext;
    logic [4:0]        pktCount;
    logic [4:0]        pktCountNext;
    logic [PtrW-1:0]   rrPtr;
    logic [PtrW-1:0]   rrPtrNext;
    logic [NumReq-1:0] grantReg;
    logic [NumReq-1:0] grantNext;

    logic              pickValid;
    logic [PtrW-1:0]   pickIdx;
    logic [NumReq-1:0] pickOneHot;
    logic [PtrW-1:0]   pickNextPtr;
    logic [PtrW-1:0]   candSel;
    int                candIdx;

    logic [BitWidth:0] startSum;
    logic [BitWidth:0] nextSum;
    logic              roomStart;
    logic              roomNext;
    logic              inIsland;
    logic              abort;
    logic              lineFree;
    logic              startOk;
    logic              driveIsland;

    // Room checks and the abort condition. An island in flight must only ever
    // see Control on period_in; anything else means the timing stream moved on
    // and the island is abandoned immediately.
    always_comb begin
        startSum  = {1'b0, x} + StartNeed;
        nextSum   = {1'b0, x} + NextNeed;
        roomStart = (startSum <= Vps);
        roomNext  = (nextSum <= Vps);
        inIsland  = (state == StPre) || (state == StLguard) ||
                    (state == StPkt) || (state == StTguard);
        abort     = inIsland && (period_in != PerControl);
        startOk   = (period_in == PerControl) && (|pktBus.req) && roomStart && lineFree;
    end

`ifdef H14TX_ISLAND_ONE_PER_LINE_EN
    localparam logic [BitWidth-1:0] LastX = BitWidth'(FrameWidth - 1);

    logic lineUsed;

    // Remember that this line already carried an island; the last pixel of
    // the line re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lineUsed <= 1'b0;
        end else if (x == LastX) begin
            lineUsed <= 1'b0;
        end else if ((state == StIdle) && startOk) begin
            lineUsed <= 1'b1;
        end
    end

    assign lineFree = !lineUsed;
`else
    assign lineFree = 1'b1;
`endif

    // Round-robin pick: scan offsets from the far end down to zero so the
    // last hit written is the lowest index at or after rrPtr.
    always_comb begin
        pickValid   = 1'b0;
        pickIdx     = '0;
        pickOneHot  = '0;
        pickNextPtr = '0;
        candIdx     = 0;
        candSel     = '0;
        for (int off = NumReq - 1; off >= 0; off--) begin
            candIdx = int'(rrPtr) + off;
            if (candIdx >= NumReq) begin
                candIdx = candIdx - NumReq;
            end
            candSel = PtrW'(candIdx);
            if (pktBus.req[candSel]) begin
                pickValid = 1'b1;
                pickIdx   = candSel;
            end
        end
        for (int i = 0; i < NumReq; i++) begin
            pickOneHot[i] = pickValid && (int'(pickIdx) == i);
        end
        if (int'(pickIdx) + 1 < NumReq) begin
            pickNextPtr = PtrW'(int'(pickIdx) + 1);
        end
    end

    // Island sequencer: IDLE -> PRE(8) -> LGUARD(2) -> PKT(32 each) ->
    // TGUARD(2) -> HOLD(HoldOff) -> IDLE. Requests are only looked at on the
    // pick cycles (last LGUARD cycle and packet index 31).
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        pktCountNext = pktCount;
        rrPtrNext    = rrPtr;
        grantNext    = grantReg;
        if (abort) begin
            stateNext    = StIdle;
            cntNext      = '0;
            pktCountNext = '0;
            grantNext    = '0;
        end else begin
            case (state)
                StIdle: begin
                    pktCountNext = '0;
                    if (startOk) begin
                        stateNext = StPre;
                        cntNext   = '0;
                    end
                end
                StPre: begin
                    if (cnt == CntW'(7)) begin
                        stateNext = StLguard;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
                StLguard: begin
                    if (cnt == CntW'(1)) begin
                        cntNext = '0;
                        if (pickValid) begin
                            stateNext    = StPkt;
                            grantNext    = pickOneHot;
                            rrPtrNext    = pickNextPtr;
                            pktCountNext = 5'd1;
                        end else begin
                            stateNext = StTguard;
                        end
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
                StPkt: begin
                    if (cnt == CntW'(31)) begin
                        cntNext = '0;
                        if (pickValid && (pktCount < 5'(MaxPackets)) && roomNext) begin
                            grantNext    = pickOneHot;
                            rrPtrNext    = pickNextPtr;
                            pktCountNext = pktCount + 5'd1;
                        end else begin
                            stateNext = StTguard;
                            grantNext = '0;
                        end
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
                StTguard: begin
                    if (cnt == CntW'(1)) begin
                        cntNext   = '0;
                        stateNext = (HoldOff == 0) ? StIdle : StHold;
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
                StHold: begin
                    if (cnt == HoldLast) begin
                        stateNext = StIdle;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt + 1'b1;
                    end
                end
                default: begin
                    stateNext = StIdle;
                    cntNext   = '0;
                end
            endcase
        end
    end

    // State registers; reset from any state lands in IDLE with a fresh
    // round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            cnt      <= '0;
            pktCount <= '0;
            rrPtr    <= '0;
            grantReg <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            pktCount <= pktCountNext;
            rrPtr    <= rrPtrNext;
            grantReg <= grantNext;
        end
    end

    // Output decode. Reset and an abort both fall back to pass-through in the
    // same cycle so the encoders never see a stale island period.
    always_comb begin
        driveIsland      = !rst && !abort;
        overrun          = abort && !rst;
        period           = period_in;
        pktBus.grant     = '0;
        pktBus.pkt_start = 1'b0;
        pktBus.pkt_idx   = 5'd0;
        if (driveIsland) begin
            case (state)
                StPre:    period = PerDataPreamble;
                StLguard: period = PerDataGuard;
                StTguard: period = PerDataGuard;
                StPkt: begin
                    period           = PerDataActive;
                    pktBus.grant     = grantReg;
                    pktBus.pkt_start = (cnt == '0);
                    pktBus.pkt_idx   = cnt[4:0];
                end
                default:  period = period_in;
            endcase
        end
    end

endmodule
